dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 132 +++++++++++++
 tb/tb_dm_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port memory arbiter: CPU (port 0) and loader/debug (port 1) share one
// single-cycle memory. Each access is IDLE (arbitrate + latch) then ACCESS
// (drive memory), giving one access every two cycles.
module dm_arbiter #(
  parameter int PRIO_MODE = 0  // 0 = round-robin, 1 = port 0 always wins ties
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  ls0,
  input  logic [3:0]  ls1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_ls,
  input  logic [31:0] mem_dout
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ls;
  } cmd_t;

  state_t      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic        last_q, last_d;   // port granted most recently
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_any, win;

  // Winner selection; a tie goes to the port not granted last unless fixed priority
  always_comb begin
    req_any = req0 | req1;
    win     = 1'b0;
    if (req0 && req1) win = (PRIO_MODE == 1) ? 1'b0 : ~last_q;
    else if (req1)    win = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: ACCESS lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs are driven only during ACCESS; otherwise all zero
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    mem_ls   = '0;
    if (state_q == ACCESS) begin
      mem_we   = cmd_q.we;
      mem_addr = cmd_q.addr;
      mem_din  = cmd_q.wdata;
      mem_ls   = cmd_q.ls;
    end
  end

  // Datapath next-state: latch winner's command, pulse gnt, then pulse done
  always_comb begin
    cmd_d   = cmd_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    gnt_d   = '0;
    done_d  = '0;
    if (state_q == IDLE && req_any) begin
      cmd_d.port  = win;
      cmd_d.we    = win ? we1    : we0;
      cmd_d.addr  = win ? addr1  : addr0;
      cmd_d.wdata = win ? wdata1 : wdata0;
      cmd_d.ls    = win ? ls1    : ls0;
      gnt_d[win]  = 1'b1;
      last_d      = win;
    end
    if (state_q == ACCESS) begin
      done_d[cmd_q.port] = 1'b1;
      if (!cmd_q.we) rdata_d = mem_dout;
    end
  end

  // Datapath registers; pointer resets to port 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
    end else begin
      cmd_q   <= cmd_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign gnt0  = gnt_q[0];
  assign gnt1  = gnt_q[1];
  assign done0 = done_q[0];
  assign done1 = done_q[1];
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a round-robin instance drives a small memory
// model; a fixed-priority instance shares the inputs for the priority checks.
module tb_dm_arbiter;
  logic        clk, rstn;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  ls0, ls1;
  logic        gnt0, gnt1, done0, done1, mem_we;
  logic [31:0] rdata, mem_addr, mem_din, mem_dout;
  logic [3:0]  mem_ls;
  logic        p_gnt0, p_gnt1, p_done0, p_done1, p_mem_we;
  logic [31:0] p_rdata, p_mem_addr, p_mem_din;
  logic [3:0]  p_mem_ls;
  logic [31:0] mem [0:15];
  int n_tests = 0;
  int n_fail  = 0;

  dm_arbiter #(.PRIO_MODE(0)) dut (
    .clk(clk), .rstn(rstn), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ls0(ls0), .ls1(ls1), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ls(mem_ls), .mem_dout(mem_dout));

  dm_arbiter #(.PRIO_MODE(1)) dut_p (
    .clk(clk), .rstn(rstn), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ls0(ls0), .ls1(ls1), .gnt0(p_gnt0), .gnt1(p_gnt1), .done0(p_done0), .done1(p_done1),
    .rdata(p_rdata), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_din(p_mem_din),
    .mem_ls(p_mem_ls), .mem_dout(mem_dout));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;
  always @(posedge clk) if (mem_we) mem[mem_addr[5:2]] <= mem_din;
  assign mem_dout = mem[mem_addr[5:2]];

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; ls0 = 0; ls1 = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    repeat (2) @(negedge clk);
    n_tests++; if ({gnt0, gnt1, done0, done1, mem_we} !== 5'b0) begin n_fail++; $display("FAIL rst_flags got=%b exp=00000", {gnt0, gnt1, done0, done1, mem_we}); end
    n_tests++; if ({rdata, mem_addr, mem_din, mem_ls} !== 100'h0) begin n_fail++; $display("FAIL rst_data got=%h exp=0", {rdata, mem_addr, mem_din, mem_ls}); end
    rstn = 1;
  endtask

  task automatic test_write();
    req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF; ls0 = 4'd2;
    @(negedge clk);
    n_tests++; if ({gnt0, gnt1, done0} !== 3'b100) begin n_fail++; $display("FAIL wr_gnt got=%b exp=100", {gnt0, gnt1, done0}); end
    n_tests++; if ({mem_we, mem_addr, mem_din, mem_ls} !== {1'b1, 32'h10, 32'hDEADBEEF, 4'd2}) begin n_fail++; $display("FAIL wr_mem got=%b %h %h %h", mem_we, mem_addr, mem_din, mem_ls); end
    idle_inputs();
    @(negedge clk);
    n_tests++; if ({gnt0, done0, done1, mem_we} !== 4'b0100) begin n_fail++; $display("FAIL wr_done got=%b exp=0100", {gnt0, done0, done1, mem_we}); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL wr_idle_addr got=%h exp=0", mem_addr); end
  endtask

  task automatic test_read();
    req1 = 1; we1 = 0; addr1 = 32'h10; ls1 = 4'd2;
    @(negedge clk);
    n_tests++; if ({gnt0, gnt1, mem_we, mem_addr} !== {3'b010, 32'h10}) begin n_fail++; $display("FAIL rd_gnt got=%b %h", {gnt0, gnt1, mem_we}, mem_addr); end
    idle_inputs();
    @(negedge clk);
    n_tests++; if ({done0, done1, rdata} !== {2'b01, 32'hDEADBEEF}) begin n_fail++; $display("FAIL rd_done got=%b %h exp=01 deadbeef", {done0, done1}, rdata); end
    @(negedge clk);
    n_tests++; if ({done1, rdata} !== {1'b0, 32'hDEADBEEF}) begin n_fail++; $display("FAIL rd_hold got=%b %h exp=0 deadbeef", done1, rdata); end
  endtask

  task automatic test_round_robin();
    int d0 = 0, d1 = 0;
    req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h10;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        n_tests++;
        if ({gnt0, gnt1} !== (((k / 2) % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL rr_gnt k=%0d got=%b", k, {gnt0, gnt1});
        end
      end else begin
        n_tests++;
        if ({gnt0, gnt1} !== 2'b00 || (done0 & done1)) begin
          n_fail++; $display("FAIL rr_done_cyc k=%0d gnt=%b done=%b", k, {gnt0, gnt1}, {done0, done1});
        end
        d0 += done0; d1 += done1;
      end
    end
    idle_inputs();
    n_tests++; if (d0 != 4 || d1 != 4) begin n_fail++; $display("FAIL rr_counts got=%0d,%0d exp=4,4", d0, d1); end
    @(negedge clk);
  endtask

  task automatic test_prio();
    req0 = 1; req1 = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        n_tests++; if ({p_gnt0, p_gnt1} !== 2'b10) begin n_fail++; $display("FAIL prio_gnt k=%0d got=%b exp=10", k, {p_gnt0, p_gnt1}); end
      end
    end
    req0 = 0;
    @(negedge clk);
    n_tests++; if ({p_gnt0, p_gnt1} !== 2'b01) begin n_fail++; $display("FAIL prio_port1 got=%b exp=01", {p_gnt0, p_gnt1}); end
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h12345678; ls0 = 4'd2;
    @(negedge clk);
    n_tests++; if ({gnt0, mem_we} !== 2'b11) begin n_fail++; $display("FAIL mid_start got=%b exp=11", {gnt0, mem_we}); end
    idle_inputs();
    #2 rstn = 0;
    #1;
    n_tests++; if (mem_we !== 1'b0 || gnt0 !== 1'b0) begin n_fail++; $display("FAIL mid_we_drop got=%b%b exp=00", mem_we, gnt0); end
    @(negedge clk);
    n_tests++; if ({done0, done1} !== 2'b00) begin n_fail++; $display("FAIL mid_no_done got=%b exp=00", {done0, done1}); end
    rstn = 1;
    @(negedge clk);
    n_tests++; if ({gnt0, gnt1, done0, done1, mem_we, mem_addr} !== 37'h0) begin n_fail++; $display("FAIL mid_idle got=%b %h", {gnt0, gnt1, done0, done1, mem_we}, mem_addr); end
  endtask

  task automatic test_tie_after_reset();
    // Aborted write to 0x20 never reached memory, so it still reads 0
    req0 = 1; req1 = 1; addr0 = 32'h20; addr1 = 32'h10;
    @(negedge clk);
    n_tests++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL tie_first got=%b exp=10", {gnt0, gnt1}); end
    req0 = 0;
    @(negedge clk);
    n_tests++; if ({done0, rdata} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL tie_abort_rd got=%b %h exp=1 0", done0, rdata); end
    @(negedge clk);
    n_tests++; if ({gnt0, gnt1} !== 2'b01) begin n_fail++; $display("FAIL tie_second got=%b exp=01", {gnt0, gnt1}); end
    idle_inputs();
    @(negedge clk);
    n_tests++; if ({done1, rdata} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL tie_rd2 got=%b %h", done1, rdata); end
  endtask

  task automatic test_back_to_back();
    req1 = 1; we1 = 1; addr1 = 32'h30; wdata1 = 32'hCAFEF00D; ls1 = 4'd1;
    @(negedge clk);
    n_tests++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt1 got=%b exp=1", gnt1); end
    idle_inputs();
    @(negedge clk);
    n_tests++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL b2b_done1 got=%b exp=1", done1); end
    req0 = 1; we0 = 0; addr0 = 32'h30;
    @(negedge clk);
    n_tests++; if ({gnt0, mem_we, mem_addr} !== {2'b10, 32'h30}) begin n_fail++; $display("FAIL b2b_gnt0 got=%b %h", {gnt0, mem_we}, mem_addr); end
    idle_inputs();
    @(negedge clk);
    n_tests++; if ({done0, rdata} !== {1'b1, 32'hCAFEF00D}) begin n_fail++; $display("FAIL b2b_rd got=%b %h exp=1 cafef00d", done0, rdata); end
  endtask

  initial begin
    idle_inputs();
    rstn = 1;
    #1;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_prio();
    test_reset_mid_access();
    test_tie_after_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
